// File: rtl/impix_panel_pkg.sv
// Shared constants for the board panel endpoint: clock rate, channel count and
// default debounce/stretch durations, plus a helper for counter sizing.
package impix_panel_pkg;

  localparam int IMPIX_CLK_HZ          = 50_000_000;
  localparam int IMPIX_PANEL_CHANNELS  = 4;
  // 10 ms of settling for switches, 100 ms of minimum LED on-time
  localparam int IMPIX_DEBOUNCE_CYCLES = IMPIX_CLK_HZ / 100;
  localparam int IMPIX_STRETCH_CYCLES  = IMPIX_CLK_HZ / 10;

  function automatic int impix_cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/impix_debounce_ch.sv
// One switch channel: 2-flop synchronizer, stability counter and accepted level.
// 'change' is combinational and flags the cycle in which 'stable' is about to flip.
module impix_debounce_ch
  import impix_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = IMPIX_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic stable,
  output logic change
);

  localparam int CW = impix_cnt_width(DEBOUNCE_CYCLES);

  logic          sync_meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          done;

  // The count completes on the mismatch cycle that would bring it to DEBOUNCE_CYCLES
  assign done   = (sync != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign change = done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= sw_raw;
      sync      <= sync_meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (done) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/impix_panel_io.sv
// Board panel endpoint: debounced switches toward the PIO and pulse-stretched LEDs.
// Optional macro IMPIX_LED_STRETCH_EN enables the LED stretch counters.
module impix_panel_io
  import impix_panel_pkg::*;
#(
  parameter int CHANNELS        = IMPIX_PANEL_CHANNELS,
  parameter int DEBOUNCE_CYCLES = IMPIX_DEBOUNCE_CYCLES,
  parameter int STRETCH_CYCLES  = IMPIX_STRETCH_CYCLES
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [CHANNELS-1:0] sw_raw,
  output logic [CHANNELS-1:0] switches_export,
  output logic                sw_change,
  input  logic [CHANNELS-1:0] indicators_export,
  output logic [CHANNELS-1:0] led
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("impix_panel_io: CHANNELS must be in 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("impix_panel_io: DEBOUNCE_CYCLES must be >= 1");
  end
  if (STRETCH_CYCLES < 1) begin : g_bad_stretch
    $error("impix_panel_io: STRETCH_CYCLES must be >= 1");
  end

  logic [CHANNELS-1:0] stable_bits;
  logic [CHANNELS-1:0] change_bits;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_sw
    impix_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk_clk),
      .rst    (reset_reset),
      .sw_raw (sw_raw[i]),
      .stable (stable_bits[i]),
      .change (change_bits[i])
    );
  end

  assign switches_export = stable_bits;

  // Registered alongside 'stable' so the strobe lines up with the new value
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sw_change <= 1'b0;
    end else begin
      sw_change <= |change_bits;
    end
  end

  logic [CHANNELS-1:0] ind_q;

`ifdef IMPIX_LED_STRETCH_EN
  localparam int SW = impix_cnt_width(STRETCH_CYCLES);

  logic [CHANNELS-1:0] stretch_active;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_stretch
    logic [SW-1:0] cnt;

    // A rising edge reloads even while running, so rapid blips extend the on-time
    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        cnt <= '0;
      end else if (indicators_export[i] && !ind_q[i]) begin
        cnt <= SW'(STRETCH_CYCLES);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end

    assign stretch_active[i] = (cnt != '0);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ind_q <= '0;
      led   <= '0;
    end else begin
      ind_q <= indicators_export;
      led   <= ind_q | stretch_active;
    end
  end
`else
  // Without stretching, two register stages keep the same LED latency
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ind_q <= '0;
      led   <= '0;
    end else begin
      ind_q <= indicators_export;
      led   <= ind_q;
    end
  end
`endif

endmodule

// File: tb/tb_impix_panel_io.sv
// Directed self-checking bench for impix_panel_io (DEBOUNCE=8, STRETCH=16, 4 channels).
// LED expectations follow whichever build IMPIX_LED_STRETCH_EN selects.
module tb_impix_panel_io;

`ifdef IMPIX_LED_STRETCH_EN
  localparam bit STRETCH_ON = 1'b1;
`else
  localparam bit STRETCH_ON = 1'b0;
`endif

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [3:0] sw_raw;
  logic [3:0] switches_export;
  logic       sw_change;
  logic [3:0] indicators_export;
  logic [3:0] led;

  int errors = 0;
  int checks = 0;

  impix_panel_io #(
    .CHANNELS       (4),
    .DEBOUNCE_CYCLES(8),
    .STRETCH_CYCLES (16)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .sw_raw           (sw_raw),
    .switches_export  (switches_export),
    .sw_change        (sw_change),
    .indicators_export(indicators_export),
    .led              (led)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stim bit k drives indicators_export[ch] for the cycle after tick k;
  // expv bit k is the required led[ch] after tick k, every other LED must be 0
  task automatic applyStimulus(input string tag, input int ch, input logic [63:0] stim,
                               input logic [63:0] expv, input int ncyc);
    logic [3:0] e;
    indicators_export     = '0;
    indicators_export[ch] = stim[0];
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      indicators_export[ch] = stim[k];
      e     = '0;
      e[ch] = expv[k];
      checkOutput(tag, {28'b0, led}, {28'b0, e});
    end
    indicators_export = '0;
    repeat (4) tick();
  endtask

  initial begin
    int chg;

    // 1: reset with switches high, then a full debounce after release
    reset_reset       = 1'b1;
    sw_raw            = 4'hF;
    indicators_export = 4'h0;
    repeat (3) tick();
    checkOutput("t1_rst_sw",  {28'b0, switches_export}, 32'h0);
    checkOutput("t1_rst_chg", {31'b0, sw_change},       32'h0);
    checkOutput("t1_rst_led", {28'b0, led},             32'h0);
    reset_reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checkOutput("t1_sw",  {28'b0, switches_export}, (k >= 10) ? 32'hF : 32'h0);
      checkOutput("t1_chg", {31'b0, sw_change},       (k == 10) ? 32'h1 : 32'h0);
    end

    // 2: settle bit 0 low, bounce it in 3-cycle phases, then hold high
    sw_raw = 4'hE;
    chg = 0;
    repeat (12) begin
      tick();
      chg += int'(sw_change);
    end
    checkOutput("t2_settle_sw",  {28'b0, switches_export}, 32'hE);
    checkOutput("t2_settle_chg", chg, 1);
    chg = 0;
    for (int p = 0; p < 10; p++) begin
      sw_raw[0] = (p % 2 == 0);
      repeat (3) begin
        tick();
        chg += int'(sw_change);
        checkOutput("t2_bounce_sw", {28'b0, switches_export}, 32'hE);
      end
    end
    checkOutput("t2_bounce_chg", chg, 0);
    sw_raw[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checkOutput("t2_sw",  {28'b0, switches_export}, (k >= 10) ? 32'hF : 32'hE);
      checkOutput("t2_chg", {31'b0, sw_change},       (k == 10) ? 32'h1 : 32'h0);
    end

    // 3: single-cycle pulse on indicator 2
    applyStimulus("t3_led", 2, 64'h1,
                  STRETCH_ON ? (64'hFFFF << 2) : 64'h4, 24);

    // 4: indicator 1 held for 40 cycles
    applyStimulus("t4_led", 1, 64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF << 2, 46);

    // 5: pulses on indicator 3 ten cycles apart retrigger the stretch
    applyStimulus("t5_led", 3, 64'h401,
                  STRETCH_ON ? (64'h3FF_FFFF << 2) : 64'h1004, 32);

    // 6: reset in the middle of a stretch and a debounce
    sw_raw = 4'h0;
    repeat (12) tick();
    checkOutput("t6_pre_sw", {28'b0, switches_export}, 32'h0);
    sw_raw            = 4'h3;
    indicators_export = 4'h4;
    tick();
    indicators_export = 4'h0;
    repeat (5) tick();
    checkOutput("t6_mid_led", {28'b0, led}, STRETCH_ON ? 32'h4 : 32'h0);
    checkOutput("t6_mid_sw",  {28'b0, switches_export}, 32'h0);
    #2;
    reset_reset = 1'b1;
    #1;
    checkOutput("t6_rst_led", {28'b0, led}, 32'h0);
    checkOutput("t6_rst_sw",  {28'b0, switches_export}, 32'h0);
    checkOutput("t6_rst_chg", {31'b0, sw_change}, 32'h0);
    repeat (2) tick();
    reset_reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checkOutput("t6_sw",  {28'b0, switches_export}, (k >= 10) ? 32'h3 : 32'h0);
      checkOutput("t6_chg", {31'b0, sw_change},       (k == 10) ? 32'h1 : 32'h0);
      checkOutput("t6_led", {28'b0, led},             32'h0);
    end
    applyStimulus("t6_restretch", 2, 64'h1,
                  STRETCH_ON ? (64'hFFFF << 2) : 64'h4, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
